// File: rtl/mcc_seq_adder.sv
// mcc_seq_adder: clocked successor to the dynamic Manchester carry chain adder.
// A precharge cycle clears the carry/sum state, then the carry ripples through
// one BLK-bit Manchester segment per evaluate cycle, LSB segment first.
// Supports add/subtract, signed overflow and valid/ready on both sides.
module mcc_seq_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NBLK = WIDTH / BLK;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBLK - 1);

  // Segment geometry must tile the operand exactly; anything else is a build error.
  generate
    if ((BLK < 1) || (BLK > WIDTH) || ((WIDTH % BLK) != 0)) begin : g_badParams
      $error("mcc_seq_adder: WIDTH must be a non-zero multiple of BLK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bEff;
  logic             r_cinEff;
  logic             r_carry;
  logic             r_cMsb;
  logic             r_cout;
  logic [WIDTH-1:0] r_sum;
  logic             r_inReady;
  logic             r_outValid;
  logic             r_busy;

  logic [BLK-1:0]   w_segA;
  logic [BLK-1:0]   w_segB;
  logic [BLK-1:0]   w_p;
  logic [BLK-1:0]   w_g;
  logic [BLK:0]     w_c;
  logic [BLK-1:0]   w_segSum;

  // One Manchester segment: propagate/generate per bit, carry rippled from the chain carry.
  always_comb begin
    w_segA   = r_a[r_idx*BLK +: BLK];
    w_segB   = r_bEff[r_idx*BLK +: BLK];
    w_p      = w_segA ^ w_segB;
    w_g      = w_segA & w_segB;
    w_c      = '0;
    w_c[0]   = r_carry;
    for (int i = 0; i < BLK; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
    w_segSum = w_p ^ w_c[BLK-1:0];
  end

  // Control FSM with registered handshake/status outputs and the datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_a        <= '0;
      r_bEff     <= '0;
      r_cinEff   <= 1'b0;
      r_carry    <= 1'b0;
      r_cMsb     <= 1'b0;
      r_cout     <= 1'b0;
      r_sum      <= '0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_inReady <= 1'b1;
          if (in_valid && r_inReady) begin
            r_a       <= a;
            r_bEff    <= b ^ {WIDTH{sub}};
            r_cinEff  <= cin ^ sub;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= PRE;
          end
        end
        PRE: begin
          r_sum   <= '0;
          r_cMsb  <= 1'b0;
          r_cout  <= 1'b0;
          r_carry <= r_cinEff;
          r_idx   <= '0;
          r_state <= EVAL;
        end
        EVAL: begin
          r_sum[r_idx*BLK +: BLK] <= w_segSum;
          r_carry                 <= w_c[BLK];
          if (r_idx == LAST_IDX) begin
            r_cMsb     <= w_c[BLK-1];
            r_cout     <= w_c[BLK];
            r_busy     <= 1'b0;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_cMsb ^ r_cout;

endmodule

// File: tb/tb_mcc_seq_adder.sv
// tb_mcc_seq_adder: directed checks on the 16/4 adder plus random sweeps
// of the 8/1 and 32/8 variants against an arithmetic reference.
module tb_mcc_seq_adder;

  logic        clk;
  logic        rst_n;

  logic        inValid, inReady, cin, sub, outValid, outReady, cout, ovf, busy;
  logic [15:0] aIn, bIn, sum;

  logic        inValid8, inReady8, cin8, sub8, outValid8, outReady8, cout8, ovf8, busy8;
  logic [7:0]  a8, b8, sum8, bEff8;
  logic [8:0]  full9;
  logic        expOvf8;

  logic        inValid32, inReady32, cin32, sub32, outValid32, outReady32, cout32, ovf32, busy32;
  logic [31:0] a32, b32, sum32, bEff32;
  logic [32:0] full33;
  logic        expOvf32;

  int checkCount = 0;
  int passCount  = 0;
  int lat;

  mcc_seq_adder #(.WIDTH(16), .BLK(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .a(aIn), .b(bIn), .cin(cin), .sub(sub), .out_valid(outValid),
    .out_ready(outReady), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  mcc_seq_adder #(.WIDTH(8), .BLK(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .in_ready(inReady8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(outValid8),
    .out_ready(outReady8), .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
  );

  mcc_seq_adder #(.WIDTH(32), .BLK(8)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid32), .in_ready(inReady32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32), .out_valid(outValid32),
    .out_ready(outReady32), .sum(sum32), .cout(cout32), .ovf(ovf32), .busy(busy32)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts the check and reports any difference.
  task automatic checkEq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Presents one operand set to the 16/4 adder and returns just after the accept edge.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s);
    @(negedge clk);
    aIn     = av;
    bIn     = bv;
    cin     = c;
    sub     = s;
    inValid = 1'b1;
    checkEq("acceptReady", 64'(inReady), 64'd1);
    @(posedge clk);
    #1 inValid = 1'b0;
  endtask

  // Waits for the result, checks latency/busy/result, optionally consumes it.
  task automatic checkOutput(input string tag, input logic [15:0] expSum, input logic expCout,
                             input logic expOvf, input logic consume);
    int n = 0;
    int busyCnt = 0;
    while (n < 100) begin
      @(negedge clk);
      if (outValid) break;
      if (busy) busyCnt++;
      n++;
    end
    checkEq({tag, "_latency"}, 64'(n), 64'd5);
    checkEq({tag, "_busyCycles"}, 64'(busyCnt), 64'd5);
    checkEq({tag, "_sum"}, 64'(sum), 64'(expSum));
    checkEq({tag, "_cout"}, 64'(cout), 64'(expCout));
    checkEq({tag, "_ovf"}, 64'(ovf), 64'(expOvf));
    checkEq({tag, "_busyLow"}, 64'(busy), 64'd0);
    if (consume) begin
      outReady = 1'b1;
      @(posedge clk);
      #1 outReady = 1'b0;
      @(negedge clk);
      checkEq({tag, "_readyAfter"}, 64'(inReady), 64'd1);
      checkEq({tag, "_validAfter"}, 64'(outValid), 64'd0);
    end
  endtask

  // Directed sequence on the 16/4 instance followed by the two random sweeps.
  initial begin
    rst_n = 1'b0;
    inValid = 1'b0; outReady = 1'b0; aIn = '0; bIn = '0; cin = 1'b0; sub = 1'b0;
    inValid8 = 1'b0; outReady8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    inValid32 = 1'b0; outReady32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;

    repeat (2) @(negedge clk);
    checkEq("rstInReady", 64'(inReady), 64'd0);
    checkEq("rstOutValid", 64'(outValid), 64'd0);
    checkEq("rstBusy", 64'(busy), 64'd0);
    checkEq("rstResult", 64'({cout, ovf, sum}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkEq("relInReady", 64'(inReady), 64'd1);
    checkEq("relOutValid", 64'(outValid), 64'd0);
    checkEq("relResult", 64'({cout, ovf, sum}), 64'd0);

    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
    checkOutput("add00FF", 16'h0100, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("addFullChain", 16'h0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("addOvf", 16'h8000, 1'b0, 1'b1, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    checkOutput("subOvf", 16'h7FFF, 1'b1, 1'b1, 1'b1);
    applyStimulus(16'h0003, 16'h0005, 1'b1, 1'b1);
    checkOutput("subBorrow", 16'hFFFD, 1'b0, 1'b0, 1'b1);

    // Backpressure: stall in DONE with a new op waiting on the input side.
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    checkOutput("bpFirst", 16'h3333, 1'b0, 1'b0, 1'b0);
    aIn = 16'h0F0F; bIn = 16'h0101; cin = 1'b0; sub = 1'b0; inValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkEq("bpStallSum", 64'(sum), 64'h3333);
      checkEq("bpStallReady", 64'(inReady), 64'd0);
      checkEq("bpStallValid", 64'(outValid), 64'd1);
    end
    outReady = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b0;
    @(negedge clk);
    checkEq("bpIdleReady", 64'(inReady), 64'd1);
    checkEq("bpIdleValid", 64'(outValid), 64'd0);
    checkEq("bpIdleBusy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 inValid = 1'b0;
    checkOutput("bpNew", 16'h1010, 1'b0, 1'b0, 1'b1);

    // Reset during the third evaluate cycle discards the operation.
    applyStimulus(16'h1111, 16'h1111, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkEq("midPartialSum", 64'(sum), 64'h0022);
    rst_n = 1'b0;
    #1;
    checkEq("midRstSum", 64'(sum), 64'd0);
    checkEq("midRstBusy", 64'(busy), 64'd0);
    checkEq("midRstReady", 64'(inReady), 64'd0);
    checkEq("midRstValid", 64'(outValid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkEq("midNoResult", 64'(outValid), 64'd0);
    checkEq("midIdleReady", 64'(inReady), 64'd1);
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    checkOutput("afterRst", 16'h5555, 1'b0, 1'b0, 1'b1);

    // WIDTH=8, BLK=1 sweep: latency NBLK+1 = 9.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
      inValid8 = 1'b1;
      bEff8   = sub8 ? ~b8 : b8;
      full9   = {1'b0, a8} + {1'b0, bEff8} + {8'd0, (sub8 ? ~cin8 : cin8)};
      expOvf8 = (a8[7] == bEff8[7]) && (full9[7] != a8[7]);
      @(posedge clk);
      #1 inValid8 = 1'b0;
      lat = 0;
      while (lat < 100) begin
        @(negedge clk);
        if (outValid8) break;
        lat++;
      end
      checkEq("sweep8Latency", 64'(lat), 64'd9);
      checkEq("sweep8Result", 64'({cout8, ovf8, sum8}), 64'({full9[8], expOvf8, full9[7:0]}));
      outReady8 = 1'b1;
      @(posedge clk);
      #1 outReady8 = 1'b0;
    end

    // WIDTH=32, BLK=8 sweep: latency NBLK+1 = 5.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a32 = $urandom; b32 = $urandom;
      cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      inValid32 = 1'b1;
      bEff32   = sub32 ? ~b32 : b32;
      full33   = {1'b0, a32} + {1'b0, bEff32} + {32'd0, (sub32 ? ~cin32 : cin32)};
      expOvf32 = (a32[31] == bEff32[31]) && (full33[31] != a32[31]);
      @(posedge clk);
      #1 inValid32 = 1'b0;
      lat = 0;
      while (lat < 100) begin
        @(negedge clk);
        if (outValid32) break;
        lat++;
      end
      checkEq("sweep32Latency", 64'(lat), 64'd5);
      checkEq("sweep32Result", 64'({cout32, ovf32, sum32}), 64'({full33[32], expOvf32, full33[31:0]}));
      outReady32 = 1'b1;
      @(posedge clk);
      #1 outReady32 = 1'b0;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
